ads1015_scan_seq: RTL and testbench

//  Sequences the byte-level i2c_rw master to scan up to four ADS1015 single-ended inputs (AIN0..AIN3).
//  Per channel: write config (single-shot, OS=1), wait for conversion, set pointer, read 2 bytes.

---
 rtl/ads1015_scan_seq_if.sv | 15 +
 rtl/ads1015_scan_seq.sv | 175 +++++++++++++++++
 tb/tb_ads1015_scan_seq.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ads1015_scan_seq_if.sv
// ads1015_scan_seq_if: byte-level command bus between the ADS1015 scan sequencer and i2c_rw
//   i2c_go    : one-cycle command strobe (master -> slave)
//   i2c_cmd   : 1=START 2=SEND 3=RECV_ACK 4=RECV_NAK 5=STOP (master -> slave)
//   i2c_wdata : byte for SEND (master -> slave)
//   i2c_rdata : byte from the last RECV_*, valid once i2c_busy is low (slave -> master)
//   i2c_busy  : i2c_rw is executing a command (slave -> master)
interface ads1015_scan_seq_if;
    logic       i2c_go;
    logic [2:0] i2c_cmd;
    logic [7:0] i2c_wdata;
    logic [7:0] i2c_rdata;
    logic       i2c_busy;
    modport master (output i2c_go, i2c_cmd, i2c_wdata, input i2c_rdata, i2c_busy);
    modport slave  (input i2c_go, i2c_cmd, i2c_wdata, output i2c_rdata, i2c_busy);
endinterface

// File: rtl/ads1015_scan_seq.sv
// ads1015_scan_seq: drives i2c_rw to scan ADS1015 AIN0..AIN3 single-shot and emit raw 12-bit codes
//   clk, rst        : clock, synchronous active-high reset
//   i2c             : command bus to i2c_rw (master side)
//   scan_en_i       : 1 = scan continuously, 0 = stop after the current channel
//   ch_mask_i       : bit n enables AINn, sampled at scan start
//   result_o        : {msb, lsb[7:4]} raw two's-complement code
//   result_ch_o     : channel of result_o
//   result_valid_o  : one-cycle strobe, result_o/result_ch_o update with it
//   scan_done_o     : one-cycle strobe after the last enabled channel of a scan
//   active_o        : high whenever the sequencer is not idle
module ads1015_scan_seq #(
    parameter logic [6:0]  ADDR7     = 7'h48,
    parameter logic [2:0]  PGA       = 3'b001,
    parameter logic [2:0]  DR        = 3'b100,
    parameter int unsigned CONV_WAIT = 24000,
    parameter int unsigned SCAN_GAP  = 6000000
) (
    input  logic                      clk,
    input  logic                      rst,
    ads1015_scan_seq_if.master        i2c,
    input  logic                      scan_en_i,
    input  logic [3:0]                ch_mask_i,
    output logic [11:0]               result_o,
    output logic [1:0]                result_ch_o,
    output logic                      result_valid_o,
    output logic                      scan_done_o,
    output logic                      active_o
);
    typedef enum logic [2:0] {IDLE, CFG, CWAIT, PTR, RD, EMIT, GAP} state_t;
    localparam logic [23:0] CW = 24'(CONV_WAIT);
    localparam logic [23:0] SG = 24'(SCAN_GAP);
    localparam logic [2:0] C_START = 3'd1, C_SEND = 3'd2, C_RACK = 3'd3, C_RNAK = 3'd4, C_STOP = 3'd5;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [1:0]  ch_q, ch_d, rch_q, rch_d;
    logic [7:0]  msb_q, msb_d;
    logic [3:0]  lsb_q, lsb_d;
    logic [11:0] result_q, result_d;
    logic        gap_q, valid_q, valid_d, done_q, done_d;
    logic [2:0]  t_cmd, n_cmd;
    logic [7:0]  t_data;
    logic        rdy, is_cmd, issue, cmds_done;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction

    // Per-state command script indexed by idx_q; n_cmd is the script length.
    always_comb begin
        t_cmd  = 3'd0;
        t_data = 8'h00;
        n_cmd  = 3'd0;
        case (state_q)
            CFG: begin
                n_cmd  = 3'd6;
                t_cmd  = idx_q == 3'd0 ? C_START : idx_q == 3'd5 ? C_STOP : C_SEND;
                t_data = idx_q == 3'd1 ? {ADDR7, 1'b0} : idx_q == 3'd2 ? 8'h01 :
                         idx_q == 3'd3 ? {2'b11, ch_q, PGA, 1'b1} : {DR, 5'b00011};
            end
            PTR: begin
                n_cmd  = 3'd4;
                t_cmd  = idx_q == 3'd0 ? C_START : idx_q == 3'd3 ? C_STOP : C_SEND;
                t_data = idx_q == 3'd1 ? {ADDR7, 1'b0} : 8'h00;
            end
            RD: begin
                n_cmd  = 3'd5;
                t_cmd  = idx_q == 3'd0 ? C_START : idx_q == 3'd1 ? C_SEND :
                         idx_q == 3'd2 ? C_RACK : idx_q == 3'd3 ? C_RNAK : C_STOP;
                t_data = {ADDR7, 1'b1};
            end
            default: ;
        endcase
    end

    // gap_q masks the cycle right after a strobe, before i2c_rw has raised busy.
    assign rdy       = !gap_q && !i2c.i2c_busy;
    assign is_cmd    = state_q inside {CFG, PTR, RD};
    assign issue     = is_cmd && rdy && idx_q < n_cmd;
    assign cmds_done = is_cmd && rdy && idx_q == n_cmd;

    assign i2c.i2c_go    = issue;
    assign i2c.i2c_cmd   = issue ? t_cmd : 3'd0;
    assign i2c.i2c_wdata = issue ? t_data : 8'h00;

    always_comb begin
        state_d  = state_q;
        idx_d    = issue ? idx_q + 3'd1 : idx_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        ch_d     = ch_q;
        msb_d    = state_q == RD && rdy && idx_q == 3'd3 ? i2c.i2c_rdata : msb_q;
        lsb_d    = state_q == RD && rdy && idx_q == 3'd4 ? i2c.i2c_rdata[7:4] : lsb_q;
        result_d = result_q;
        rch_d    = rch_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (scan_en_i && |ch_mask_i) begin
                ch_d    = lowest(ch_mask_i);
                mask_d  = ch_mask_i & (ch_mask_i - 4'd1);
                state_d = CFG;
            end
            CFG: if (cmds_done) begin
                cnt_d   = CW;
                state_d = CW == 24'd0 ? PTR : CWAIT;
            end
            CWAIT: begin
                cnt_d   = cnt_q - 24'd1;
                state_d = cnt_q == 24'd1 ? PTR : CWAIT;
            end
            PTR: state_d = cmds_done ? RD : PTR;
            RD:  state_d = cmds_done ? EMIT : RD;
            EMIT: begin
                valid_d  = 1'b1;
                result_d = {msb_q, lsb_q};
                rch_d    = ch_q;
                if (!scan_en_i) state_d = IDLE;
                else if (|mask_q) begin
                    ch_d    = lowest(mask_q);
                    mask_d  = mask_q & (mask_q - 4'd1);
                    state_d = CFG;
                end else begin
                    done_d  = 1'b1;
                    cnt_d   = SG;
                    state_d = SG == 24'd0 ? IDLE : GAP;
                end
            end
            GAP: begin
                cnt_d   = cnt_q - 24'd1;
                state_d = cnt_q == 24'd1 ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) idx_d = 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            ch_q     <= '0;
            msb_q    <= '0;
            lsb_q    <= '0;
            result_q <= '0;
            rch_q    <= '0;
            gap_q    <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            ch_q     <= ch_d;
            msb_q    <= msb_d;
            lsb_q    <= lsb_d;
            result_q <= result_d;
            rch_q    <= rch_d;
            gap_q    <= issue;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign result_o       = result_q;
    assign result_ch_o    = rch_q;
    assign result_valid_o = valid_q;
    assign scan_done_o    = done_q;
    assign active_o       = state_q != IDLE;
endmodule

// File: tb/tb_ads1015_scan_seq.sv
// tb_ads1015_scan_seq: randomized bench with an i2c_rw/ADS1015 behavioural model and transaction-level scoreboard
module tb_ads1015_scan_seq;
    localparam int CW = 100;
    localparam int SG = 40;
    localparam int TMO = 20000;

    logic        clk = 1'b0, rst = 1'b1, scan_en = 1'b0;
    logic [3:0]  ch_mask = 4'd0;
    logic [11:0] result;
    logic [1:0]  result_ch;
    logic        result_valid, scan_done, active;

    ads1015_scan_seq_if bus();

    ads1015_scan_seq #(.CONV_WAIT(CW), .SCAN_GAP(SG)) dut (
        .clk(clk), .rst(rst), .i2c(bus), .scan_en_i(scan_en), .ch_mask_i(ch_mask),
        .result_o(result), .result_ch_o(result_ch), .result_valid_o(result_valid),
        .scan_done_o(scan_done), .active_o(active)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    logic [10:0] log_op[$], exp_op[$];
    int          log_cyc[$], res_cyc[$], done_cyc[$];
    logic [13:0] res_q[$], exp_res[$];
    logic [7:0]  rd_q[$];
    int          busy_max = 0, busy_cnt = 0, go_busy = 0, cyc = 0;
    bit          act_seen = 0, have_rd = 0;
    logic [7:0]  nxt_rd = 8'h00;

    // i2c_rw + ADS1015 model: busy for a random time after each command,
    // RECV bytes come from rd_q (0xFF when the device is absent).
    initial begin
        bus.i2c_busy  = 1'b0;
        bus.i2c_rdata = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                busy_cnt = 0;
                have_rd = 0;
                bus.i2c_busy = 1'b0;
            end else begin
                if (have_rd) begin
                    bus.i2c_rdata = nxt_rd;
                    have_rd = 0;
                end
                bus.i2c_busy = busy_cnt > 0;
                if (busy_cnt > 0) busy_cnt--;
                #1;
                if (bus.i2c_go) begin
                    if (bus.i2c_busy) go_busy++;
                    log_op.push_back({bus.i2c_cmd, bus.i2c_cmd == 3'd2 ? bus.i2c_wdata : 8'h00});
                    log_cyc.push_back(cyc);
                    if (bus.i2c_cmd inside {3'd3, 3'd4}) begin
                        nxt_rd = rd_q.size() > 0 ? rd_q.pop_front() : 8'hFF;
                        have_rd = 1;
                    end
                    busy_cnt = busy_max == 0 ? 0 : int'($urandom_range(1, busy_max));
                end
                if (result_valid) begin
                    res_q.push_back({result_ch, result});
                    res_cyc.push_back(cyc);
                end
                if (scan_done) done_cyc.push_back(cyc);
                if (active) act_seen = 1;
            end
        end
    end

    task automatic clear_logs();
        log_op.delete(); log_cyc.delete(); res_q.delete(); res_cyc.delete(); done_cyc.delete();
        exp_op.delete(); exp_res.delete(); rd_q.delete();
        go_busy = 0;
        act_seen = 0;
    endtask

    // Reference: one channel = config write, pointer write, 2-byte read; result = {hi, lo[7:4]}.
    task automatic exp_channel(input logic [1:0] c, input logic [7:0] hi, input logic [7:0] lo);
        exp_op.push_back({3'd1, 8'h00}); exp_op.push_back({3'd2, 8'h90}); exp_op.push_back({3'd2, 8'h01});
        exp_op.push_back({3'd2, {2'b11, c, 3'b001, 1'b1}}); exp_op.push_back({3'd2, 8'h83});
        exp_op.push_back({3'd5, 8'h00});
        exp_op.push_back({3'd1, 8'h00}); exp_op.push_back({3'd2, 8'h90}); exp_op.push_back({3'd2, 8'h00});
        exp_op.push_back({3'd5, 8'h00});
        exp_op.push_back({3'd1, 8'h00}); exp_op.push_back({3'd2, 8'h91}); exp_op.push_back({3'd3, 8'h00});
        exp_op.push_back({3'd4, 8'h00}); exp_op.push_back({3'd5, 8'h00});
        rd_q.push_back(hi);
        rd_q.push_back(lo);
        exp_res.push_back({c, hi, lo[7:4]});
    endtask

    task automatic prep_mask(input logic [3:0] m);
        for (int c = 0; c < 4; c++)
            if (m[c]) exp_channel(2'(c), 8'($urandom), 8'($urandom));
    endtask

    task automatic run_scan(input logic [3:0] m, output bit to);
        int n = 0;
        to = 0;
        ch_mask = m;
        scan_en = 1'b1;
        while (done_cyc.size() == 0 && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) to = 1;
        scan_en = 1'b0;
        n = 0;
        while (active && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) to = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.i2c_go, bus.i2c_cmd, bus.i2c_wdata} !== 12'h000) begin
            fails++; $display("FAIL reset_bus got go/cmd/wdata %b/%0d/%h want 0/0/00", bus.i2c_go, bus.i2c_cmd, bus.i2c_wdata);
        end
        checks++;
        if ({result_ch, result} !== 14'h0) begin
            fails++; $display("FAIL reset_result got ch %0d res %h want 0 000", result_ch, result);
        end
        checks++;
        if ({result_valid, scan_done, active} !== 3'b000) begin
            fails++; $display("FAIL reset_flags got valid/done/active %b%b%b want 000", result_valid, scan_done, active);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        bit to;
        clear_logs();
        busy_max = 0;
        exp_channel(2'd0, 8'h67, 8'hF0);
        run_scan(4'b0001, to);
        checks++;
        if (to) begin fails++; $display("FAIL single_timeout got timeout want completion"); end
        checks++;
        if (log_op.size() != exp_op.size()) begin
            fails++; $display("FAIL single_len got %0d cmds want %0d", log_op.size(), exp_op.size());
        end
        for (int i = 0; i < exp_op.size(); i++) begin
            checks++;
            if (i >= log_op.size() || log_op[i] !== exp_op[i]) begin
                fails++; $display("FAIL single_cmd[%0d] got %h want %h", i, i < log_op.size() ? log_op[i] : 11'h7FF, exp_op[i]);
            end
        end
        checks++;
        if (res_q.size() != 1 || res_q[0] !== {2'd0, 12'h67F}) begin
            fails++; $display("FAIL single_result got n=%0d %h want n=1 067F", res_q.size(), res_q.size() ? res_q[0] : 14'h0);
        end
        checks++;
        if (done_cyc.size() != 1 || res_cyc.size() != 1 || done_cyc[0] != res_cyc[0]) begin
            fails++; $display("FAIL single_done got done=%0d valid=%0d strobes want 1 each coincident", done_cyc.size(), res_cyc.size());
        end
    endtask

    task automatic test_two_channel();
        bit to;
        clear_logs();
        busy_max = 3;
        prep_mask(4'b1010);
        run_scan(4'b1010, to);
        checks++;
        if (to) begin fails++; $display("FAIL two_timeout got timeout want completion"); end
        checks++;
        if (log_op.size() != 30 || log_op[3] !== {3'd2, 8'hD3} || log_op[18] !== {3'd2, 8'hF3}) begin
            fails++; $display("FAIL two_cfg_msb got n=%0d %h/%h want 30 2d3/2f3", log_op.size(),
                              log_op.size() > 3 ? log_op[3] : 11'h0, log_op.size() > 18 ? log_op[18] : 11'h0);
        end
        for (int i = 0; i < exp_op.size(); i++) begin
            checks++;
            if (i >= log_op.size() || log_op[i] !== exp_op[i]) begin
                fails++; $display("FAIL two_cmd[%0d] got %h want %h", i, i < log_op.size() ? log_op[i] : 11'h7FF, exp_op[i]);
            end
        end
        checks++;
        if (res_q.size() != 2 || res_q[0] !== exp_res[0] || res_q[1] !== exp_res[1]) begin
            fails++; $display("FAIL two_results got n=%0d want 2 (%h,%h)", res_q.size(), exp_res[0], exp_res[1]);
        end
        checks++;
        if (done_cyc.size() != 1 || res_cyc.size() != 2 || done_cyc[0] != res_cyc[1]) begin
            fails++; $display("FAIL two_done got done=%0d valid=%0d want 1 done with 2nd valid", done_cyc.size(), res_cyc.size());
        end
    endtask

    task automatic test_mask_zero();
        clear_logs();
        ch_mask = 4'd0;
        scan_en = 1'b1;
        repeat (10000) @(negedge clk);
        scan_en = 1'b0;
        @(negedge clk);
        checks++;
        if (log_op.size() != 0) begin fails++; $display("FAIL mask0_go got %0d commands want 0", log_op.size()); end
        checks++;
        if (act_seen) begin fails++; $display("FAIL mask0_active got active=1 want 0"); end
    endtask

    task automatic test_scan_en_drop();
        int n = 0;
        clear_logs();
        busy_max = 3;
        exp_channel(2'd0, 8'($urandom), 8'($urandom));
        ch_mask = 4'b0011;
        scan_en = 1'b1;
        while (log_op.size() < 6 && n < TMO) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        scan_en = 1'b0;
        while (active && n < TMO) begin @(negedge clk); n++; end
        repeat (200) @(negedge clk);
        checks++;
        if (n >= TMO) begin fails++; $display("FAIL drop_timeout got timeout want idle"); end
        checks++;
        if (log_op.size() != 15) begin fails++; $display("FAIL drop_len got %0d cmds want 15", log_op.size()); end
        for (int i = 0; i < exp_op.size(); i++) begin
            checks++;
            if (i >= log_op.size() || log_op[i] !== exp_op[i]) begin
                fails++; $display("FAIL drop_cmd[%0d] got %h want %h", i, i < log_op.size() ? log_op[i] : 11'h7FF, exp_op[i]);
            end
        end
        checks++;
        if (res_q.size() != 1 || res_q[0] !== exp_res[0] || done_cyc.size() != 0) begin
            fails++; $display("FAIL drop_emit got results=%0d done=%0d want 1 result %h, 0 done", res_q.size(), done_cyc.size(), exp_res[0]);
        end
    endtask

    task automatic test_busy_random();
        bit to;
        logic [3:0] m;
        clear_logs();
        busy_max = 40;
        m = 4'($urandom_range(1, 15));
        prep_mask(m);
        run_scan(m, to);
        checks++;
        if (to) begin fails++; $display("FAIL busy_timeout got timeout want completion (mask %b)", m); end
        checks++;
        if (log_op.size() != exp_op.size()) begin
            fails++; $display("FAIL busy_len got %0d cmds want %0d", log_op.size(), exp_op.size());
        end
        for (int i = 0; i < exp_op.size(); i++) begin
            checks++;
            if (i >= log_op.size() || log_op[i] !== exp_op[i]) begin
                fails++; $display("FAIL busy_cmd[%0d] got %h want %h", i, i < log_op.size() ? log_op[i] : 11'h7FF, exp_op[i]);
            end
        end
        for (int i = 0; i < exp_res.size(); i++) begin
            checks++;
            if (i >= res_q.size() || res_q[i] !== exp_res[i]) begin
                fails++; $display("FAIL busy_result[%0d] got %h want %h", i, i < res_q.size() ? res_q[i] : 14'h0, exp_res[i]);
            end
        end
        checks++;
        if (go_busy != 0) begin fails++; $display("FAIL busy_go got %0d strobes while busy want 0", go_busy); end
        for (int k = 0; k < exp_res.size(); k++) begin
            checks++;
            if (log_cyc.size() <= 15 * k + 6 || log_cyc[15 * k + 6] - log_cyc[15 * k + 5] < CW) begin
                fails++; $display("FAIL busy_convwait[%0d] got %0d cycles want >= %0d", k,
                                  log_cyc.size() > 15 * k + 6 ? log_cyc[15 * k + 6] - log_cyc[15 * k + 5] : -1, CW);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int n = 0;
        clear_logs();
        busy_max = 0;
        ch_mask = 4'b0001;
        scan_en = 1'b1;
        while (log_op.size() < 4 && n < TMO) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (n >= TMO || bus.i2c_go !== 1'b0 || active !== 1'b0) begin
            fails++; $display("FAIL midreset_state got go=%b active=%b want 0 0", bus.i2c_go, active);
        end
        rst = 1'b0;
        clear_logs();
        exp_channel(2'd0, 8'($urandom), 8'($urandom));
        run_scan(4'b0001, to);
        checks++;
        if (to || log_op.size() < 2 || log_op[0] !== {3'd1, 8'h00} || log_op[1] !== {3'd2, 8'h90}) begin
            fails++; $display("FAIL midreset_restart got n=%0d first %h %h want START then SEND 90", log_op.size(),
                              log_op.size() > 0 ? log_op[0] : 11'h0, log_op.size() > 1 ? log_op[1] : 11'h0);
        end
        checks++;
        if (log_op.size() != 15 || res_q.size() != 1 || res_q[0] !== exp_res[0]) begin
            fails++; $display("FAIL midreset_scan got cmds=%0d results=%0d want 15 and 1 (%h)", log_op.size(), res_q.size(), exp_res[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_channel();
        test_mask_zero();
        test_scan_en_drop();
        test_busy_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
